// File: rtl/alu_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// iteration count and the operand magnitude helper.
package alu_pkg;

    localparam int unsigned MUL_ITERS = 32;
    localparam int unsigned CNT_W     = 6;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } mul_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/adder32.sv
// 32-bit unsigned adder; overflow is the carry out of bit 31.
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        overflow
);

    assign {overflow, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential 32x32->64 shift-add multiplier, one iteration per cycle.
// Define ALU_MUL_SIGNED_EN to add the op_signed port and the sign-fix state.
module alu_mul_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
`ifdef ALU_MUL_SIGNED_EN
    input  logic        op_signed,
`endif
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        busy
);

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(MUL_ITERS - 1);

    mul_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      mcand_q;
    logic [31:0]      acc_hi_q;
    logic [31:0]      acc_lo_q;

    logic [31:0]      lat_a;
    logic [31:0]      lat_b;
    logic [31:0]      add_sum;
    logic             add_ovf;
    logic [31:0]      add_hi;
    logic             add_c;

`ifdef ALU_MUL_SIGNED_EN
    logic             sign_q;
    logic             lat_sign;
    logic [63:0]      neg_prod;

    // Iterate on magnitudes; the sign is reapplied in StFix.
    always_comb begin
        lat_a    = op_signed ? abs32(op_a) : op_a;
        lat_b    = op_signed ? abs32(op_b) : op_b;
        lat_sign = op_signed & (op_a[31] ^ op_b[31]);
    end

    assign neg_prod = ~{acc_hi_q, acc_lo_q} + 64'd1;
`else
    always_comb begin
        lat_a = op_a;
        lat_b = op_b;
    end
`endif

    adder32 u_adder32 (
        .a        (acc_hi_q),
        .b        (mcand_q),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    // The multiplier lives in acc_lo_q and is consumed from the LSB as the product shifts in.
    always_comb begin
        add_c  = 1'b0;
        add_hi = acc_hi_q;
        if (acc_lo_q[0]) begin
            add_c  = add_ovf;
            add_hi = add_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            req_ready <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            res_hi    <= '0;
            res_lo    <= '0;
`ifdef ALU_MUL_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else if (flush) begin
            state_q   <= StIdle;
            req_ready <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        state_q   <= StRun;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        cnt_q     <= '0;
                        mcand_q   <= lat_a;
                        acc_hi_q  <= '0;
                        acc_lo_q  <= lat_b;
`ifdef ALU_MUL_SIGNED_EN
                        sign_q    <= lat_sign;
`endif
                    end
                end
                StRun: begin
                    acc_hi_q <= {add_c, add_hi[31:1]};
                    acc_lo_q <= {add_hi[0], acc_lo_q[31:1]};
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LastIter) begin
`ifdef ALU_MUL_SIGNED_EN
                        state_q <= StFix;
`else
                        state_q <= StDone;
`endif
                    end
                end
                StFix: begin
`ifdef ALU_MUL_SIGNED_EN
                    if (sign_q) begin
                        {acc_hi_q, acc_lo_q} <= neg_prod;
                    end
`endif
                    state_q <= StDone;
                end
                StDone: begin
                    // First DONE cycle publishes the product; later ones wait for the consumer.
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                        res_hi    <= acc_hi_q;
                        res_lo    <= acc_lo_q;
                    end else if (res_ready) begin
                        state_q   <= StIdle;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed cases plus random operands
// compared against an arithmetic product model.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        busy;
`ifdef ALU_MUL_SIGNED_EN
    logic        op_signed;
    localparam int Lat = 34;
`else
    localparam int Lat = 33;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_prod;
    logic        cur_signed;

    alu_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op_a      (op_a),
        .op_b      (op_b),
`ifdef ALU_MUL_SIGNED_EN
        .op_signed (op_signed),
`endif
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_hi    (res_hi),
        .res_lo    (res_lo),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        op_a      = a;
        op_b      = b;
        req_valid = 1'b1;
`ifdef ALU_MUL_SIGNED_EN
        op_signed = cur_signed;
`endif
        step();
        req_valid = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
`ifdef ALU_MUL_SIGNED_EN
        op_signed = ~cur_signed;
`endif
        check("busy_run", {63'd0, busy}, 64'd1);
        check("req_ready_run", {63'd0, req_ready}, 64'd0);
        check("hold_prev_in_run", {res_hi, res_lo}, last_prod);
    endtask

    task automatic wait_result(input string tag, input logic [63:0] exp);
        int lat = 0;
        while (!res_valid && lat < 200) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(Lat));
        check({tag, "_product"}, {res_hi, res_lo}, exp);
        last_prod = exp;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("valid_after_hs", {63'd0, res_valid}, 64'd0);
        check("busy_after_hs", {63'd0, busy}, 64'd0);
        check("ready_after_hs", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          seen;

        rst_n      = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        res_ready  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        cur_signed = 1'b0;
`ifdef ALU_MUL_SIGNED_EN
        op_signed  = 1'b0;
`endif
        last_prod  = 64'd0;
        step();
        step();
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_result", {res_hi, res_lo}, 64'd0);
        rst_n = 1'b1;
        step();
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);

        // 3*5 with res_ready held high throughout
        res_ready = 1'b1;
        start(32'd3, 32'd5);
        wait_result("three_five", 64'd15);
        consume();

        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("all_ones", 64'hFFFF_FFFE_0000_0001);
        consume();

        start(32'd0, 32'hDEAD_BEEF);
        wait_result("zero_a", 64'd0);
        consume();

        // Back-pressure: result held for 10 cycles, extra request ignored
        a = $urandom;
        b = $urandom;
        start(a, b);
        wait_result("backpressure", model(a, b, cur_signed));
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", {63'd0, res_valid}, 64'd1);
            check("bp_stable", {res_hi, res_lo}, last_prod);
            check("bp_req_ready", {63'd0, req_ready}, 64'd0);
        end
        req_valid = 1'b0;
        consume();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (res_valid) seen++;
        end
        check("bp_single_hs", 64'(seen), 64'd0);

        // Flush part way through the iterations
        start(32'h1234_5678, 32'h9ABC_DEF0);
        repeat (12) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_req_ready", {63'd0, req_ready}, 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid) seen++;
            step();
        end
        check("flush_no_valid", 64'(seen), 64'd0);
        check("flush_hold", {res_hi, res_lo}, last_prod);
        start(32'd7, 32'd6);
        wait_result("after_flush", 64'd42);
        consume();

        // Reset in the middle of RUN
        start(32'hCAFE_F00D, 32'h0BAD_BEEF);
        repeat (20) step();
        rst_n = 1'b0;
        step();
        check("midrst_valid", {63'd0, res_valid}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_result", {res_hi, res_lo}, 64'd0);
        rst_n = 1'b1;
        last_prod = 64'd0;
        step();
        check("midrst_ready", {63'd0, req_ready}, 64'd1);
        a = $urandom;
        b = $urandom;
        start(a, b);
        wait_result("after_rst", model(a, b, cur_signed));
        consume();

`ifdef ALU_MUL_SIGNED_EN
        cur_signed = 1'b1;
        start(32'hFFFF_FFFD, 32'd5);
        wait_result("signed_neg", 64'hFFFF_FFFF_FFFF_FFF1);
        consume();
        cur_signed = 1'b0;
        start(32'hFFFF_FFFD, 32'd5);
        wait_result("unsigned_same", 64'h0000_0004_FFFF_FFF1);
        consume();
`endif

        // Random operands with random consumer delay
        for (int n = 0; n < 10; n++) begin
            a = $urandom;
            b = $urandom;
            if (n % 3 == 0) a[31] = 1'b1;
`ifdef ALU_MUL_SIGNED_EN
            cur_signed = 1'($urandom_range(0, 1));
`endif
            exp = model(a, b, cur_signed);
            start(a, b);
            wait_result("random", exp);
            repeat ($urandom_range(0, 3)) begin
                step();
                check("random_hold", {res_hi, res_lo}, exp);
            end
            consume();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
